spwm_cordic_sched: RTL
======================

SPWM_CORDIC_SCHED -- requirements
Module: spwm_cordic_sched

Interface
REQ-001 Parameter NCH, default 3: number of phase channels sharing one CORDIC.
REQ-002 Parameter LAT, default 16: CORDIC pipeline latency in clocks, issue to result.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 enable  input  1  run request; sampled only in IDLE and READY.
REQ-006 increment  input  16  phase step per committed PWM period, unsigned, zero-extended to 20 bits.
REQ-007 phase_off_1, phase_off_2  input  20 each  phase offsets of channels 1 and 2; channel 0 offset is 0.
REQ-008 period_start  input  1  one-cycle pulse at PWM counter wrap (commit opportunity).
REQ-009 overrun_clr  input  1  clears sticky overrun.
REQ-010 cordic_z  output  20  angle presented to the CORDIC.
REQ-011 cordic_issue  output  1  high in the cycle cordic_z is valid.
REQ-012 cordic_x  input  17  signed CORDIC result, valid exactly LAT cycles after its issue cycle.
REQ-013 duty0, duty1, duty2  output  18 each  unsigned biased duty per channel.
REQ-014 duty_update  output  1  one-cycle pulse when duties change.
REQ-015 busy  output  1  high in ISSUE and WAIT.
REQ-016 overrun  output  1  sticky: period_start arrived before results were ready.

Function
REQ-017 The FSM SHALL have four states: IDLE, ISSUE, WAIT, READY.
REQ-018 IDLE with enable=1: go to ISSUE next cycle; the accumulator is not incremented on this first pass.
REQ-019 ISSUE SHALL last NCH consecutive cycles; in cycle k: cordic_issue=1, cordic_z = (acc + off_k) mod 2^20.
REQ-020 Each issue SHALL push a valid bit and a channel tag into an LAT-deep tag pipeline.
REQ-021 Capture: when the tag pipeline output is valid, shadow[tag] <= sign_extend18(cordic_x) + 65536, giving range 0..131071.
REQ-022 After the ISSUE state, the FSM SHALL stay in WAIT until the tag for channel NCH-1 is captured, then enter READY.
REQ-023 Timing: with issues at t0..t0+2, captures SHALL occur at t0+16..t0+18 and READY SHALL begin at t0+19.
REQ-024 READY with period_start=1: duty[k] <= shadow[k] for all k; duty_update=1 for that single cycle; acc <= (acc + increment) mod 2^20; go to ISSUE.
REQ-025 READY with enable=0 and period_start=0: go to IDLE; duties hold their values.
REQ-026 READY with enable=0 and period_start=1: commit as in REQ-024, then go to IDLE instead of ISSUE.
REQ-027 period_start in ISSUE or WAIT: set overrun; no commit; duties hold; the sequence continues and commits on the next period_start seen in READY.
REQ-028 period_start in IDLE: ignored.
REQ-029 overrun_clr clears overrun; if a set condition occurs in the same cycle, set wins.
REQ-030 enable deasserted during ISSUE or WAIT: the sequence completes to READY.
REQ-031 Accumulator wrap-around: modulo 2^20, silent.
REQ-032 Offset additions wrap modulo 2^20, silent.

Reset
REQ-033 Reset values: state IDLE, acc 0, shadow and duty0..2 = 65536 (18'h10000), cordic_z 0, cordic_issue 0, duty_update 0, busy 0, overrun 0, tag pipeline cleared.
REQ-034 Reset asserted mid-sequence SHALL discard in-flight tags; CORDIC results arriving after reset release SHALL NOT be captured.

Verification
REQ-035 Scenario: release reset with enable=1, CORDIC stub returns 0 -> cordic_issue high 3 cycles with z = 0, phase_off_1, phase_off_2; READY at issue+19; at the first period_start duties = 65536/65536/65536 and exactly one duty_update pulse.
REQ-036 Scenario: stub returns -65536, 65535, 0 for channels 0/1/2 -> after commit duty0=0, duty1=131071, duty2=65536.
REQ-037 Scenario: increment=0x1000, off1=0x55555, off2=0xAAAAA -> second pass issues z = 0x01000, 0x56555, 0xABAAA.
REQ-038 Scenario: acc=0xFF000, increment=0x1000, commit -> next channel-0 z = 0x00000.
REQ-039 Scenario: period_start during WAIT -> overrun=1, no duty_update, duties unchanged; next period_start commits; overrun_clr together with a new overrun in the same cycle leaves overrun=1.
REQ-040 Scenario: rst_n low during WAIT -> all outputs at reset values; stub results arriving after release leave duties at 65536.

Source files
------------

// File: rtl/spwm_cordic_sched_if.sv
// Request/result link between the SPWM scheduler (master) and a shared pipelined CORDIC (slave).
interface spwm_cordic_sched_if;
    logic [19:0]        cordic_z;
    logic               cordic_issue;
    logic signed [16:0] cordic_x;

    modport master (output cordic_z, output cordic_issue, input cordic_x);
    modport slave  (input cordic_z, input cordic_issue, output cordic_x);
endinterface

// File: rtl/spwm_cordic_sched.sv
// Time-shares one pipelined CORDIC across NCH SPWM phase channels and double-buffers
// the biased results so the duties only change at a PWM counter wrap.
module spwm_cordic_sched #(
    parameter int NCH = 3,
    parameter int LAT = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                enable,
    input  logic [15:0]         increment,
    input  logic [19:0]         phase_off_1,
    input  logic [19:0]         phase_off_2,
    input  logic                period_start,
    input  logic                overrun_clr,
    spwm_cordic_sched_if.master cordic,
    output logic [17:0]         duty0,
    output logic [17:0]         duty1,
    output logic [17:0]         duty2,
    output logic                duty_update,
    output logic                busy,
    output logic                overrun
);
    localparam int TW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [TW-1:0] LAST_CH = TW'(NCH - 1);
    localparam logic [17:0] MID = 18'h10000;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, READY} state_t;

    state_t         state;
    state_t         state_nx;
    logic [19:0]    acc;
    logic [19:0]    offset;
    logic [TW-1:0]  chan;
    logic [LAT-1:0] pipe_vld;
    logic [TW-1:0]  pipe_tag [LAT];
    logic [17:0]    shadow [NCH];
    logic [17:0]    duty [NCH];
    logic           commit;
    logic           cap_last;

    always_comb begin
        offset = '0;
        if (chan == TW'(1))      offset = phase_off_1;
        else if (chan == TW'(2)) offset = phase_off_2;
    end

    // WAIT ends on the capture of the last channel's tag, not on a cycle count
    assign cap_last = pipe_vld[LAT-1] && (pipe_tag[LAT-1] == LAST_CH);

    always_comb begin
        state_nx = state;
        commit   = 1'b0;
        case (state)
            IDLE:  if (enable) state_nx = ISSUE;
            ISSUE: if (chan == LAST_CH) state_nx = WAIT;
            WAIT:  if (cap_last) state_nx = READY;
            READY: begin
                if (period_start) begin
                    commit   = 1'b1;
                    state_nx = enable ? ISSUE : IDLE;
                end else if (!enable) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    assign cordic.cordic_issue = (state == ISSUE);
    assign cordic.cordic_z     = (state == ISSUE) ? acc + offset : '0;
    assign duty_update         = commit;
    assign busy                = (state == ISSUE) || (state == WAIT);
    assign duty0               = duty[0];
    assign duty1               = duty[1];
    assign duty2               = duty[2];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            chan  <= '0;
            acc   <= '0;
        end else begin
            state <= state_nx;
            chan  <= (state == ISSUE) ? chan + TW'(1) : '0;
            if (commit) acc <= acc + {4'd0, increment};
        end
    end

    // Tag pipeline mirrors the CORDIC latency so each result finds its channel
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_vld <= '0;
            for (int i = 0; i < LAT; i++) pipe_tag[i] <= '0;
        end else begin
            pipe_vld[0] <= (state == ISSUE);
            pipe_tag[0] <= chan;
            for (int i = 1; i < LAT; i++) begin
                pipe_vld[i] <= pipe_vld[i-1];
                pipe_tag[i] <= pipe_tag[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NCH; i++) begin
                shadow[i] <= MID;
                duty[i]   <= MID;
            end
        end else begin
            if (pipe_vld[LAT-1])
                shadow[pipe_tag[LAT-1]] <= {cordic.cordic_x[16], cordic.cordic_x} + MID;
            if (commit)
                for (int i = 0; i < NCH; i++) duty[i] <= shadow[i];
        end
    end

    // A wrap that arrives while results are still in flight is a sticky overrun
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                   overrun <= 1'b0;
        else if (period_start && busy) overrun <= 1'b1;
        else if (overrun_clr)         overrun <= 1'b0;
    end
endmodule
